alu_uart_interface: RTL and testbench

Sequential front-end that drives the ALU's operand/opcode inputs from a UART byte stream and returns the ALU outputs over UART. It sits between the UART receiver/transmitter and the combinational ALU. Three received bytes (A, B, opcode) are registered onto the ALU inputs. The result byte is then transmitted, followed by a flags byte.

---
 rtl/alu_uart_interface_if.sv | 29 ++
 rtl/alu_uart_interface.sv | 117 +++++++++++
 tb/tb_alu_uart_interface.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_interface_if.sv
// Bundle of the UART byte stream and ALU operand/result signals seen by alu_uart_interface.
// The slave modport is the FSM side; the master modport is the UART/ALU side.
interface alu_uart_interface_if #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP_CODE = 6,
    parameter int NB_BYTE    = 8
) ();
    logic [NB_BYTE-1:0]    i_rx_data;
    logic                  i_rx_done;
    logic [NB_BYTE-1:0]    o_tx_data;
    logic                  o_tx_start;
    logic                  i_tx_done;
    logic [NB_DATA-1:0]    o_data_a;
    logic [NB_DATA-1:0]    o_data_b;
    logic [NB_OP_CODE-1:0] o_op_code;
    logic [NB_DATA-1:0]    i_alu_result;
    logic                  i_alu_zero;
    logic                  i_alu_carry;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_zero, i_alu_carry,
        output o_tx_data, o_tx_start, o_data_a, o_data_b, o_op_code
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_zero, i_alu_carry,
        input  o_tx_data, o_tx_start, o_data_a, o_data_b, o_op_code
    );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects A, B and opcode bytes from the UART receiver onto the ALU inputs, then sends
// the ALU result byte followed by a {carry, zero} flags byte back through the transmitter.
module alu_uart_interface #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP_CODE = 6,
    parameter int NB_BYTE    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    alu_uart_interface_if.slave  bus,
    output logic                 o_busy
);
    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND_RES,
        WAIT_RES,
        SEND_FLG,
        WAIT_FLG
    } state_t;

    state_t                r_state;
    logic [NB_DATA-1:0]    r_data_a;
    logic [NB_DATA-1:0]    r_data_b;
    logic [NB_OP_CODE-1:0] r_op_code;
    logic [NB_BYTE-1:0]    r_tx_data;
    logic                  r_tx_start;
    logic [NB_BYTE-1:0]    r_flags;
    logic                  r_busy;
    logic [NB_BYTE-1:0]    w_result_ext;
    logic [NB_BYTE-1:0]    w_flags_ext;

    always_comb begin
        w_result_ext                = '0;
        w_result_ext[NB_DATA-1:0]   = bus.i_alu_result;
        w_flags_ext                 = '0;
        w_flags_ext[1:0]            = {bus.i_alu_carry, bus.i_alu_zero};
    end

    // The result byte is loaded straight into the tx register on leaving EXEC so that
    // o_tx_data is already valid in the same cycle o_tx_start is raised.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= WAIT_A;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_op_code  <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_flags    <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                WAIT_A: begin
                    if (bus.i_rx_done) begin
                        r_data_a <= bus.i_rx_data[NB_DATA-1:0];
                        r_busy   <= 1'b1;
                        r_state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.i_rx_done) begin
                        r_data_b <= bus.i_rx_data[NB_DATA-1:0];
                        r_state  <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        r_op_code <= bus.i_rx_data[NB_OP_CODE-1:0];
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_tx_data  <= w_result_ext;
                    r_flags    <= w_flags_ext;
                    r_tx_start <= 1'b1;
                    r_state    <= SEND_RES;
                end
                SEND_RES: begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (bus.i_tx_done) begin
                        r_tx_data  <= r_flags;
                        r_tx_start <= 1'b1;
                        r_state    <= SEND_FLG;
                    end
                end
                SEND_FLG: begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_FLG;
                end
                WAIT_FLG: begin
                    if (bus.i_tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= WAIT_A;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_data_a   = r_data_a;
    assign bus.o_data_b   = r_data_b;
    assign bus.o_op_code  = r_op_code;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_start = r_tx_start;
    assign o_busy         = r_busy;
endmodule

// File: tb/tb_alu_uart_interface.sv
// Scoreboard bench for alu_uart_interface: a behavioural ALU and transmitter surround the DUT,
// expected tx bytes are queued per command and popped by a monitor on every o_tx_start.
module tb_alu_uart_interface;
    logic clk;
    logic rst_n;
    logic busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb_q[$];
    bit   saw_99 = 1'b0;

    alu_uart_interface_if #(.NB_DATA(8), .NB_OP_CODE(6), .NB_BYTE(8)) ifc ();

    alu_uart_interface #(.NB_DATA(8), .NB_OP_CODE(6), .NB_BYTE(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifc),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {carry, zero, result[7:0]}; carry on SUB means no borrow.
    function automatic logic [9:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        logic [8:0] t;
        t = '0;
        case (op)
            6'h20: t = {1'b0, a} + {1'b0, b};
            6'h22: t = {1'b0, a} + {1'b0, ~b} + 9'd1;
            6'h24: t = {1'b0, a & b};
            6'h25: t = {1'b0, a | b};
            6'h26: t = {1'b0, a ^ b};
            6'h27: t = {1'b0, ~(a | b)};
            6'h03: t = {1'b0, 8'($signed(a) >>> b[2:0])};
            6'h02: t = {1'b0, a >> b[2:0]};
            default: t = '0;
        endcase
        return {t[8], (t[7:0] == 8'h00), t[7:0]};
    endfunction

    always_comb begin
        {ifc.i_alu_carry, ifc.i_alu_zero, ifc.i_alu_result} =
            alu_model(ifc.o_data_a, ifc.o_data_b, ifc.o_op_code);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model: finishes each byte a few cycles after o_tx_start.
    int tx_cnt = 0;
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            tx_cnt = 0;
            ifc.i_tx_done = 1'b0;
        end else begin
            ifc.i_tx_done = 1'b0;
            if (ifc.o_tx_start) begin
                tx_cnt = 3;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) ifc.i_tx_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every o_tx_start and checks data holds until i_tx_done.
    bit         prev_start = 1'b0;
    bit         inflight   = 1'b0;
    logic [7:0] held       = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
            inflight   = 1'b0;
        end else begin
            if (ifc.o_data_a == 8'h99) saw_99 = 1'b1;
            if (inflight) check("tx_stable", 32'(ifc.o_tx_data), 32'(held));
            if (ifc.o_tx_start) begin
                check("start_single", 32'(prev_start), 32'd0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx: got 0x%0h expected no transmission", ifc.o_tx_data);
                end else begin
                    check("tx_byte", 32'(ifc.o_tx_data), 32'(sb_q.pop_front()));
                end
                held     = ifc.o_tx_data;
                inflight = 1'b1;
            end
            if (ifc.i_tx_done) inflight = 1'b0;
            prev_start = ifc.o_tx_start;
        end
    end

    task automatic rx_byte(input logic [7:0] d);
        @(negedge clk);
        ifc.i_rx_data = d;
        ifc.i_rx_done = 1'b1;
        @(negedge clk);
        ifc.i_rx_done = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.o_tx_start) break;
        end
        check("start_timeout", 32'(ifc.o_tx_start), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] res, input logic [7:0] flg,
                            input bit lat, input bit inject);
        $display("cmd a=0x%02h b=0x%02h op=0x%02h -> res=0x%02h flg=0x%02h", a, b, op, res, flg);
        sb_q.push_back(res);
        sb_q.push_back(flg);
        rx_byte(a);
        rx_byte(b);
        rx_byte(op);
        if (lat) begin
            check("lat_exec", 32'(ifc.o_tx_start), 32'd0);
            @(negedge clk);
            check("lat_send", 32'(ifc.o_tx_start), 32'd1);
        end
        if (inject) begin
            if (!ifc.o_tx_start) wait_start();
            rx_byte(8'h99);
        end
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, 32'(ifc.o_tx_data), 32'd0);
        check({tag, "_tx_start"}, 32'(ifc.o_tx_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_data_a"}, 32'(ifc.o_data_a), 32'd0);
        check({tag, "_data_b"}, 32'(ifc.o_data_b), 32'd0);
        check({tag, "_op_code"}, 32'(ifc.o_op_code), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [8];
        logic [7:0] a, b, opb;
        logic [9:0] r;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

        rst_n         = 1'b0;
        ifc.i_rx_data = '0;
        ifc.i_rx_done = 1'b0;
        ifc.i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        send_cmd(8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 1'b1, 1'b0);
        check("add_data_a", 32'(ifc.o_data_a), 32'h05);
        check("add_data_b", 32'(ifc.o_data_b), 32'h03);
        check("add_op_code", 32'(ifc.o_op_code), 32'h20);

        send_cmd(8'hFF, 8'h01, 8'h20, 8'h00, 8'h03, 1'b0, 1'b0);
        send_cmd(8'h05, 8'h05, 8'h22, 8'h00, 8'h03, 1'b0, 1'b0);
        send_cmd(8'h03, 8'h05, 8'h22, 8'hFE, 8'h00, 1'b0, 1'b1);
        send_cmd(8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h00, 1'b0, 1'b0);
        check("no_99_capture", 32'(saw_99), 32'd0);
        check("or_data_a", 32'(ifc.o_data_a), 32'h0F);

        // Unsupported opcode with upper bits set: only the low 6 bits reach the ALU.
        send_cmd(8'h12, 8'h34, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0);
        check("op_truncated", 32'(ifc.o_op_code), 32'h3F);

        // Reset while waiting for the result byte to finish.
        $display("cmd a=0xf0 b=0x0f op=0x24 interrupted by reset in WAIT_RES");
        sb_q.push_back(8'h00);
        sb_q.push_back(8'h01);
        rx_byte(8'hF0);
        rx_byte(8'h0F);
        rx_byte(8'h24);
        wait_start();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_cmd(8'hF0, 8'h0F, 8'h24, 8'h00, 8'h01, 1'b1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            opb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) opb = ops[$urandom_range(0, 7)] | (opb & 8'hC0);
            r = alu_model(a, b, opb[5:0]);
            send_cmd(a, b, opb, r[7:0], {6'b0, r[9:8]}, 1'b0, 1'b0);
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
